// File: rtl/alu_pkg.sv
// Shared ALU definitions: function codes and the result-decoder state encoding.
package alu_pkg;

    localparam logic [1:0] FUNC_ADD = 2'b00;
    localparam logic [1:0] FUNC_SUB = 2'b01;
    localparam logic [1:0] FUNC_MUL = 2'b10;
    localparam logic [1:0] FUNC_DIV = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        FIN   = 2'd2
    } state_t;

endpackage

// File: rtl/bcd_add3.sv
// Per-digit double-dabble correction: any digit of 5 or more gets +3 before the next shift.
module bcd_add3 (
    input  logic [3:0] din,
    output logic [3:0] dout
);

    assign dout = (din >= 4'd5) ? (din + 4'd3) : din;

endmodule

// File: rtl/alu_result_bcd.sv
// Converts a captured ALU result word to packed BCD with a fixed-latency
// shift-and-add-3 engine; div results are split into quotient and remainder digits.
module alu_result_bcd
    import alu_pkg::*;
#(
    parameter int WIDTH = 6,
    parameter int HDIG  = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [1:0]              func,
    input  logic [2*WIDTH-1:0]      res,
    input  logic                    ovf,
    output logic                    busy,
    output logic                    done,
    output logic [8*HDIG-1:0]       bcd,
    output logic                    neg,
    output logic                    err,
    output logic                    split
);

    localparam int NDIG = 2 * HDIG;
    localparam int RW   = 2 * WIDTH;
    localparam int BW   = 4 * NDIG;
    localparam int HB   = 4 * HDIG;
    localparam int CW   = $clog2(RW + 1);

    state_t           state_reg, state_next;
    logic [CW-1:0]    cnt_reg, cnt_next;
    logic [RW-1:0]    src_reg, src_next;
    logic [BW-1:0]    acc_reg, acc_next, acc_adj;
    logic [1:0]       func_reg, func_next;
    logic             ovf_reg, ovf_next;
    logic             sign_reg, sign_next;
    logic             busy_reg, busy_next;
    logic             done_reg, done_next;
    logic [BW-1:0]    bcd_reg, bcd_next;
    logic             neg_reg, neg_next;
    logic             err_reg, err_next;
    logic             split_reg, split_next;

    logic [WIDTH-1:0] low_w, mag_w;

    assign low_w = res[WIDTH-1:0];
    // Two's-complement negate; the most negative value maps onto its own unsigned magnitude.
    assign mag_w = low_w[WIDTH-1] ? ((~low_w) + WIDTH'(1)) : low_w;

    genvar gi;
    generate
        for (gi = 0; gi < NDIG; gi++) begin : g_digit
            bcd_add3 u_add3 (
                .din  (acc_reg[4*gi +: 4]),
                .dout (acc_adj[4*gi +: 4])
            );
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        src_next   = src_reg;
        acc_next   = acc_reg;
        func_next  = func_reg;
        ovf_next   = ovf_reg;
        sign_next  = sign_reg;
        busy_next  = busy_reg;
        done_next  = 1'b0;
        bcd_next   = bcd_reg;
        neg_next   = neg_reg;
        err_next   = err_reg;
        split_next = split_reg;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = SHIFT;
                    cnt_next   = '0;
                    acc_next   = '0;
                    func_next  = func;
                    ovf_next   = ovf;
                    sign_next  = 1'b0;
                    busy_next  = 1'b1;
                    case (func)
                        FUNC_ADD: src_next = {{WIDTH{1'b0}}, low_w};
                        FUNC_SUB: begin
                            src_next  = {{WIDTH{1'b0}}, mag_w};
                            sign_next = low_w[WIDTH-1];
                        end
                        default:  src_next = res;
                    endcase
                end
            end
            SHIFT: begin
                src_next = {src_reg[RW-2:0], 1'b0};
                cnt_next = cnt_reg + CW'(1);
                if (func_reg == FUNC_DIV) begin
                    // Halves are independent: only the half being fed is corrected and shifted.
                    if (cnt_reg < CW'(WIDTH))
                        acc_next = {acc_adj[BW-2:HB], src_reg[RW-1], acc_reg[HB-1:0]};
                    else
                        acc_next = {acc_reg[BW-1:HB], acc_adj[HB-2:0], src_reg[RW-1]};
                end else begin
                    acc_next = {acc_adj[BW-2:0], src_reg[RW-1]};
                end
                if (cnt_reg == CW'(RW - 1))
                    state_next = FIN;
            end
            FIN: begin
                state_next = IDLE;
                busy_next  = 1'b0;
                done_next  = 1'b1;
                bcd_next   = acc_reg;
                neg_next   = sign_reg;
                err_next   = ovf_reg;
                split_next = (func_reg == FUNC_DIV);
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            src_reg   <= '0;
            acc_reg   <= '0;
            func_reg  <= FUNC_ADD;
            ovf_reg   <= 1'b0;
            sign_reg  <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            bcd_reg   <= '0;
            neg_reg   <= 1'b0;
            err_reg   <= 1'b0;
            split_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            src_reg   <= src_next;
            acc_reg   <= acc_next;
            func_reg  <= func_next;
            ovf_reg   <= ovf_next;
            sign_reg  <= sign_next;
            busy_reg  <= busy_next;
            done_reg  <= done_next;
            bcd_reg   <= bcd_next;
            neg_reg   <= neg_next;
            err_reg   <= err_next;
            split_reg <= split_next;
        end
    end

    assign busy  = busy_reg;
    assign done  = done_reg;
    assign bcd   = bcd_reg;
    assign neg   = neg_reg;
    assign err   = err_reg;
    assign split = split_reg;

endmodule

// File: tb/tb_alu_result_bcd.sv
// Scoreboarded bench for alu_result_bcd: expected digit tuples are queued at start and checked at done.
module tb_alu_result_bcd;

    localparam int WIDTH = 6;
    localparam int HDIG  = 2;
    localparam int LAT   = 2 * WIDTH + 1;

    typedef struct packed {
        logic [15:0] bcd;
        logic        neg;
        logic        err;
        logic        split;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  func = 2'b00;
    logic [11:0] res = '0;
    logic        ovf = 1'b0;
    logic        busy, done, neg, err, split;
    logic [15:0] bcd;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    alu_result_bcd #(.WIDTH(WIDTH), .HDIG(HDIG)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .func  (func),
        .res   (res),
        .ovf   (ovf),
        .busy  (busy),
        .done  (done),
        .bcd   (bcd),
        .neg   (neg),
        .err   (err),
        .split (split)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] dec(input int v, input int nd);
        logic [15:0] d;
        int          x;
        d = '0;
        x = v;
        for (int i = 0; i < nd; i++) begin
            d[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return d;
    endfunction

    function automatic exp_t model(input logic [1:0] f, input logic [11:0] r, input logic o);
        exp_t        e;
        logic [15:0] q, m;
        e = '0;
        e.err = o;
        case (f)
            2'b00: e.bcd = dec(int'(r[5:0]), 4);
            2'b01: begin
                e.neg = r[5];
                e.bcd = dec(r[5] ? 64 - int'(r[5:0]) : int'(r[5:0]), 4);
            end
            2'b10: e.bcd = dec(int'(r), 4);
            default: begin
                q = dec(int'(r[11:6]), 2);
                m = dec(int'(r[5:0]), 2);
                e.bcd = {q[7:0], m[7:0]};
                e.split = 1'b1;
            end
        endcase
        return e;
    endfunction

    // Drives one conversion and returns the start-to-done edge count (-1 on timeout).
    // If poke > 0, a stray start is pulsed after that many edges of the conversion.
    task automatic do_conv(input logic [1:0] f, input logic [11:0] r, input logic o,
                           input int poke, output int lat);
        @(negedge clk);
        func = f; res = r; ovf = o; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = -1;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (done) begin
                lat = n;
                break;
            end
            if (n == poke) begin
                start = 1'b1; func = 2'b10; res = 12'hABC; ovf = 1'b1;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        $display("txn func=%b res=%h ovf=%b -> bcd=%h neg=%b err=%b split=%b lat=%0d",
                 f, r, o, bcd, neg, err, split, lat);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({busy, done, bcd, neg, err, split} !== 21'd0) begin
            n_err++;
            $display("FAIL reset_state got=%h want=0", {busy, done, bcd, neg, err, split});
        end
        rst_n = 1'b1;
    endtask

    task automatic test_add();
        exp_t e; int lat;
        sb.push_back('{bcd: 16'h0045, neg: 1'b0, err: 1'b0, split: 1'b0});
        do_conv(2'b00, 12'h02D, 1'b0, 0, lat);
        e = sb.pop_front();
        n_cmp++;
        if ({bcd, neg, err, split} !== e) begin
            n_err++; $display("FAIL add got=%h want=%h", {bcd, neg, err, split}, e);
        end
        n_cmp++;
        if (lat != LAT) begin
            n_err++; $display("FAIL add_latency got=%0d want=%0d", lat, LAT);
        end
    endtask

    task automatic test_sub();
        exp_t e; int lat;
        sb.push_back('{bcd: 16'h0005, neg: 1'b1, err: 1'b0, split: 1'b0});
        do_conv(2'b01, 12'h03B, 1'b0, 0, lat);
        e = sb.pop_front();
        n_cmp++;
        if ({bcd, neg, err, split} !== e || lat != LAT) begin
            n_err++; $display("FAIL sub_neg5 got=%h lat=%0d want=%h lat=%0d", {bcd, neg, err, split}, lat, e, LAT);
        end
        sb.push_back('{bcd: 16'h0032, neg: 1'b1, err: 1'b0, split: 1'b0});
        do_conv(2'b01, 12'hFA0, 1'b0, 0, lat);
        e = sb.pop_front();
        n_cmp++;
        if ({bcd, neg, err, split} !== e || lat != LAT) begin
            n_err++; $display("FAIL sub_min got=%h lat=%0d want=%h lat=%0d", {bcd, neg, err, split}, lat, e, LAT);
        end
    endtask

    task automatic test_mul();
        exp_t e; int lat;
        sb.push_back('{bcd: 16'h4095, neg: 1'b0, err: 1'b0, split: 1'b0});
        do_conv(2'b10, 12'hFFF, 1'b0, 0, lat);
        e = sb.pop_front();
        n_cmp++;
        if ({bcd, neg, err, split} !== e || lat != LAT) begin
            n_err++; $display("FAIL mul_max got=%h lat=%0d want=%h lat=%0d", {bcd, neg, err, split}, lat, e, LAT);
        end
    endtask

    task automatic test_div();
        exp_t e; int lat;
        sb.push_back('{bcd: 16'h4705, neg: 1'b0, err: 1'b0, split: 1'b1});
        do_conv(2'b11, {6'd47, 6'd5}, 1'b0, 0, lat);
        e = sb.pop_front();
        n_cmp++;
        if ({bcd, neg, err, split} !== e || lat != LAT) begin
            n_err++; $display("FAIL div got=%h lat=%0d want=%h lat=%0d", {bcd, neg, err, split}, lat, e, LAT);
        end
    endtask

    task automatic test_ovf();
        exp_t e; int lat;
        sb.push_back('{bcd: 16'h0062, neg: 1'b0, err: 1'b1, split: 1'b0});
        do_conv(2'b00, 12'h03E, 1'b1, 0, lat);
        e = sb.pop_front();
        n_cmp++;
        if ({bcd, neg, err, split} !== e || lat != LAT) begin
            n_err++; $display("FAIL add_ovf got=%h lat=%0d want=%h lat=%0d", {bcd, neg, err, split}, lat, e, LAT);
        end
    endtask

    task automatic test_busy_start();
        exp_t e; int lat; int extra;
        sb.push_back('{bcd: 16'h0059, neg: 1'b0, err: 1'b0, split: 1'b0});
        do_conv(2'b00, 12'h03B, 1'b0, 4, lat);
        e = sb.pop_front();
        n_cmp++;
        if ({bcd, neg, err, split} !== e) begin
            n_err++; $display("FAIL busy_start_result got=%h want=%h", {bcd, neg, err, split}, e);
        end
        n_cmp++;
        if (lat != LAT) begin
            n_err++; $display("FAIL busy_start_latency got=%0d want=%0d", lat, LAT);
        end
        extra = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (done || busy) extra++;
        end
        n_cmp++;
        if (extra != 0) begin
            n_err++; $display("FAIL busy_start_queued got=%0d active cycles want=0", extra);
        end
    endtask

    task automatic test_reset_mid();
        int seen;
        @(negedge clk);
        func = 2'b10; res = 12'h123; ovf = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({busy, done, bcd, neg, err, split} !== 21'd0) begin
            n_err++; $display("FAIL reset_mid_outputs got=%h want=0", {busy, done, bcd, neg, err, split});
        end
        rst_n = 1'b1;
        seen = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (done || busy) seen++;
        end
        $display("txn reset mid-conversion -> post-reset active cycles=%0d", seen);
        n_cmp++;
        if (seen != 0) begin
            n_err++; $display("FAIL reset_mid_no_done got=%0d want=0", seen);
        end
    endtask

    task automatic test_after_reset();
        exp_t e; int lat;
        sb.push_back(model(2'b11, {6'd63, 6'd63}, 1'b0));
        do_conv(2'b11, {6'd63, 6'd63}, 1'b0, 0, lat);
        e = sb.pop_front();
        n_cmp++;
        if ({bcd, neg, err, split} !== e || lat != LAT) begin
            n_err++; $display("FAIL after_reset got=%h lat=%0d want=%h lat=%0d", {bcd, neg, err, split}, lat, e, LAT);
        end
    endtask

    task automatic test_back_to_back();
        exp_t        e;
        int          lat;
        logic [1:0]  f;
        logic [11:0] r;
        logic        o;
        for (int i = 0; i < 12; i++) begin
            f = 2'($urandom_range(0, 3));
            r = 12'($urandom);
            o = 1'($urandom);
            sb.push_back(model(f, r, o));
            do_conv(f, r, o, 0, lat);
            e = sb.pop_front();
            n_cmp++;
            if ({bcd, neg, err, split} !== e || lat != LAT) begin
                n_err++;
                $display("FAIL b2b_%0d func=%b res=%h got=%h lat=%0d want=%h lat=%0d",
                         i, f, r, {bcd, neg, err, split}, lat, e, LAT);
            end
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_mul();
        test_div();
        test_ovf();
        test_busy_start();
        test_reset_mid();
        test_after_reset();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
